time_set_ctrl: RTL and testbench



---
 rtl/time_set_ctrl.sv | 178 +++++++++++++++++
 tb/tb_time_set_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - watch time-setting sequencer: capture, field edit with range wrap, commit strobe
// Optional macro AUTO_REPEAT_EN: held up/down auto-repeat steps in EDIT.
module time_set_ctrl #(
    parameter int BLINK_DIV   = 25000000,
    parameter int YEAR_MAX    = 99
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DLY  = 12500000,
    parameter int REPEAT_RATE = 2500000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_mode,
    input  logic [3:0]  btn,
    input  logic [47:0] bin_time,
    output logic [47:0] set_time,
    output logic        load,
    output logic        editing,
    output logic [2:0]  cursor,
    output logic        blink
);

    typedef enum logic [1:0] {RUN, CAPTURE, EDIT, COMMIT} state_t;

    localparam logic [47:0] TIME_RST = {8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0};

    state_t      state;
    logic [3:0]  btn_q;
    logic [3:0]  press;
    logic [31:0] blink_cnt;

    logic        edit_act;
    logic        step_up;
    logic        step_dn;
    logic        act_up;
    logic        act_dn;
    logic        act_next;
    logic        act_prev;
    logic [7:0]  cur_val;
    logic [7:0]  fmin;
    logic [7:0]  fmax;
    logic [7:0]  new_val;
    logic [7:0]  clamp_day;
    logic [47:0] new_time;

    function automatic logic [7:0] maxday(input logic [7:0] month, input logic [7:0] year);
        case (month)
            8'd2:                    return (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
            default:                 return 8'd31;
        endcase
    endfunction

    assign press    = btn & ~btn_q;
    assign edit_act = (state == EDIT) && set_mode;

`ifdef AUTO_REPEAT_EN
    logic [31:0] hold_cnt;
    logic        rep_armed;
    logic        rep_fire;

    // First repeat waits REPEAT_DLY after the press, then every REPEAT_RATE.
    always_comb begin
        rep_fire = (state == EDIT) && (btn[0] | btn[1]) && !(press[0] | press[1]) &&
                   (hold_cnt == (rep_armed ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DLY - 1)));
    end

    assign step_up = press[0] | (rep_fire & btn[0]);
    assign step_dn = press[1] | (rep_fire & btn[1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt  <= 32'd0;
            rep_armed <= 1'b0;
        end else if (!edit_act || !(btn[0] | btn[1]) || press[0] || press[1] || act_next || act_prev) begin
            hold_cnt  <= 32'd0;
            rep_armed <= 1'b0;
        end else if (rep_fire) begin
            hold_cnt  <= 32'd0;
            rep_armed <= 1'b1;
        end else begin
            hold_cnt  <= hold_cnt + 32'd1;
        end
    end
`else
    assign step_up = press[0];
    assign step_dn = press[1];
`endif

    always_comb begin
        act_up   = edit_act && step_up;
        act_dn   = edit_act && !step_up && step_dn;
        act_next = edit_act && !step_up && !step_dn && press[2];
        act_prev = edit_act && !step_up && !step_dn && !press[2] && press[3];

        cur_val = set_time[{cursor, 3'b000} +: 8];
        case (cursor)
            3'd0, 3'd1: begin fmin = 8'd1 - 8'd1; fmax = 8'd59; end
            3'd2:       begin fmin = 8'd0; fmax = 8'd23; end
            3'd3:       begin fmin = 8'd1; fmax = maxday(set_time[39:32], set_time[47:40]); end
            3'd4:       begin fmin = 8'd1; fmax = 8'd12; end
            default:    begin fmin = 8'd0; fmax = 8'(YEAR_MAX); end
        endcase

        if (act_up)
            new_val = (cur_val < fmin || cur_val >= fmax) ? fmin : cur_val + 8'd1;
        else
            new_val = (cur_val <= fmin || cur_val > fmax) ? fmax : cur_val - 8'd1;

        new_time = set_time;
        new_time[{cursor, 3'b000} +: 8] = new_val;

        // Month/year edits pull the day down into the new month's range.
        clamp_day = maxday(new_time[39:32], new_time[47:40]);
        if (cursor >= 3'd4 && new_time[31:24] > clamp_day)
            new_time[31:24] = clamp_day;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            set_time  <= TIME_RST;
            load      <= 1'b0;
            editing   <= 1'b0;
            cursor    <= 3'd0;
            blink     <= 1'b0;
            blink_cnt <= 32'd0;
            btn_q     <= 4'd0;
        end else begin
            btn_q <= btn;
            load  <= 1'b0;
            case (state)
                RUN: begin
                    blink <= 1'b0;
                    if (set_mode) begin
                        state   <= CAPTURE;
                        editing <= 1'b1;
                    end
                end
                CAPTURE: begin
                    set_time  <= bin_time;
                    cursor    <= 3'd0;
                    blink     <= 1'b0;
                    blink_cnt <= 32'd0;
                    state     <= EDIT;
                end
                EDIT: begin
                    if (!set_mode) begin
                        state <= COMMIT;
                        load  <= 1'b1;
                        blink <= 1'b0;
                    end else if (act_up || act_dn) begin
                        set_time  <= new_time;
                        blink     <= 1'b1;
                        blink_cnt <= 32'd0;
                    end else if (act_next) begin
                        cursor    <= (cursor == 3'd5) ? 3'd0 : cursor + 3'd1;
                        blink_cnt <= 32'd0;
                    end else if (act_prev) begin
                        cursor    <= (cursor == 3'd0) ? 3'd5 : cursor - 3'd1;
                        blink_cnt <= 32'd0;
                    end else if (blink_cnt == 32'(BLINK_DIV - 1)) begin
                        blink     <= ~blink;
                        blink_cnt <= 32'd0;
                    end else begin
                        blink_cnt <= blink_cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= RUN;
                    editing <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        set_mode;
    logic [3:0]  btn;
    logic [47:0] bin_time;
    logic [47:0] set_time;
    logic        load;
    logic        editing;
    logic [2:0]  cursor;
    logic        blink;

    int errors = 0;
    int checks = 0;
    int load_seen = 0;
    int load_base;

    time_set_ctrl #(.BLINK_DIV(4), .YEAR_MAX(99)) dut (
        .clk      (clk),
        .rst      (rst),
        .set_mode (set_mode),
        .btn      (btn),
        .bin_time (bin_time),
        .set_time (set_time),
        .load     (load),
        .editing  (editing),
        .cursor   (cursor),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load) load_seen++;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] b);
        btn = b;
        tick();
        btn = 4'd0;
        tick();
    endtask

    initial begin
        rst = 1'b0; set_mode = 1'b0; btn = 4'd0;
        bin_time = 48'h18_0C_1F_17_3B_3B;
        tick(2);
        chk("rst_set_time", set_time, 48'h00_01_01_00_00_00);
        chk("rst_load", load, 0);
        chk("rst_editing", editing, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_blink", blink, 0);

        rst = 1'b1;
        tick();
        set_mode = 1'b1;
        tick();
        chk("capture_editing", editing, 1);
        tick();
        chk("capture_time", set_time, 48'h18_0C_1F_17_3B_3B);
        chk("capture_cursor", cursor, 0);
        chk("capture_load", load, 0);

        push(4'b0001);
        chk("sec_up_wrap", set_time[7:0], 8'd0);
        push(4'b0010);
        chk("sec_down_wrap", set_time[7:0], 8'd59);
        push(4'b0100); push(4'b0100);
        chk("cursor_next2", cursor, 2);
        push(4'b0001);
        chk("hour_up_wrap", set_time[23:16], 8'd0);
        push(4'b0010);
        chk("hour_down_wrap", set_time[23:16], 8'd23);
        push(4'b1000); push(4'b1000); push(4'b1000);
        chk("prev_wrap", cursor, 5);
        push(4'b0100);
        chk("next_wrap", cursor, 0);
        push(4'b0101);
        chk("up_next_val", set_time[7:0], 8'd0);
        chk("up_next_cursor", cursor, 0);

        // Time is now 24-12-31 23:59:00, cursor on seconds.
        push(4'b1000);
        push(4'b0010);
        chk("year_down", set_time[47:40], 8'd23);
        push(4'b1000);
        push(4'b0001);
        chk("month_wrap", set_time[39:32], 8'd1);
        chk("day_jan", set_time[31:24], 8'd31);
        push(4'b0001);
        chk("month_feb23", set_time[39:32], 8'd2);
        chk("clamp_feb23", set_time[31:24], 8'd28);
        push(4'b0010);
        push(4'b1000);
        push(4'b0001); push(4'b0001); push(4'b0001);
        chk("day_up_31", set_time[31:24], 8'd31);
        push(4'b0100); push(4'b0100);
        push(4'b0001);
        chk("year_up_24", set_time[47:40], 8'd24);
        push(4'b1000);
        push(4'b0001);
        chk("clamp_feb24", set_time[31:24], 8'd29);
        push(4'b1000);
        push(4'b0001);
        chk("day_up_wrap_29", set_time[31:24], 8'd1);

        btn = 4'b0001;
        tick();
        chk("blink_forced", blink, 1);
        btn = 4'd0;
        tick(3);
        chk("blink_hold", blink, 1);
        tick();
        chk("blink_toggle0", blink, 0);
        tick(4);
        chk("blink_toggle1", blink, 1);

        load_base = load_seen;
        set_mode = 1'b0;
        btn = 4'b0001;
        tick();
        btn = 4'd0;
        chk("commit_load", load, 1);
        chk("commit_time", set_time, 48'h18_02_02_17_3B_00);
        chk("commit_editing", editing, 1);
        chk("commit_blink", blink, 0);
        tick();
        chk("run_load", load, 0);
        chk("run_editing", editing, 0);
        push(4'b0001);
        chk("run_press_ignored", set_time, 48'h18_02_02_17_3B_00);
        chk("one_load_pulse", load_seen - load_base, 1);

        set_mode = 1'b1;
        tick(2);
        push(4'b0001);
        chk("edit2_sec_up", set_time[7:0], 8'd0);
        load_base = load_seen;
        #2 rst = 1'b0;
        #1;
        chk("arst_set_time", set_time, 48'h00_01_01_00_00_00);
        chk("arst_editing", editing, 0);
        chk("arst_cursor", cursor, 0);
        chk("arst_blink", blink, 0);
        set_mode = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        chk("arst_no_load", load_seen - load_base, 0);
        chk("arst_run", editing, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
